rca32_adder: RTL and testbench

- Registered 32-bit ripple-carry adder: sum = a + b + cin, with carry-out.
- Datapath is an explicit chain of 1-bit full-adder cells, with carry rippling bit 0 to bit WIDTH-1; no lookahead or prefix logic.
- Result is captured in an output register with a valid flag.
- Serves as the integer add primitive for the 32-bit MIPS datapath (ALU add/sub, PC increment).

---
 rtl/rca32_adder.sv | 78 +++++++
 tb/tb_rca32_adder.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/rca32_adder.sv
// Registered WIDTH-bit ripple-carry adder built from a generated chain of full-adder cells.
// Define RCA32_FLAGS_EN to add registered signed-overflow and zero flags.

module rca32_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic p;
  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);
endmodule

module rca32_adder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             out_valid
`ifdef RCA32_FLAGS_EN
  ,
  output logic             overflow,
  output logic             zero
`endif
);
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  assign c[0] = cin;

  // Carry ripples strictly bit 0 -> WIDTH-1 through one cell per bit.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    rca32_fa u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum       <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      // Idle cycles keep the last result, so junk on the operands is never sampled.
      if (in_valid) begin
        sum  <= s;
        cout <= c[WIDTH];
      end
    end
  end

`ifdef RCA32_FLAGS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else if (in_valid) begin
      overflow <= c[WIDTH] ^ c[WIDTH-1];
      zero     <= (s == '0);
    end
  end
`endif

endmodule

// File: tb/tb_rca32_adder.sv
// Scoreboard bench for rca32_adder: stimulus pushes expected register state, a monitor pops and compares.
// Flag checks are compiled in when RCA32_FLAGS_EN is defined.

module tb_rca32_adder;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] a, b;
  logic         cin;
  logic [W-1:0] sum;
  logic         cout;
  logic         out_valid;
`ifdef RCA32_FLAGS_EN
  logic         overflow, zero;
`endif

  rca32_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sum       (sum),
    .cout      (cout),
    .out_valid (out_valid)
`ifdef RCA32_FLAGS_EN
    ,
    .overflow  (overflow),
    .zero      (zero)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic         vld;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  // Reference state: what the output registers should hold after the next edge.
  logic [W-1:0] m_sum  = '0;
  logic         m_cout = 1'b0;
  logic         m_ovf  = 1'b0;
  logic         m_zero = 1'b0;

  task automatic step(input string nm, input logic r, input logic v,
                      input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic);
    exp_t e;
    longint unsigned u;
    longint          sg;
    rst_n = r; in_valid = v; a = ia; b = ib; cin = ic;
    e.vld = 1'b0;
    if (!r) begin
      m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0; m_zero = 1'b0;
    end else if (v) begin
      u  = longint'(ia) + longint'(ib) + longint'(ic);
      sg = longint'($signed(ia)) + longint'($signed(ib)) + longint'(ic);
      m_sum  = u[W-1:0];
      m_cout = u[W];
      m_ovf  = (sg > 64'sd2147483647) || (sg < -64'sd2147483648);
      m_zero = (m_sum == 0);
      e.vld  = 1'b1;
    end
    e.name = nm; e.sum = m_sum; e.cout = m_cout; e.ovf = m_ovf; e.zero = m_zero;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: one expected entry is consumed after every edge.
  initial begin
    exp_t e;
    logic ok;
    forever begin
      @(negedge clk);
      if (exp_q.size() == 0) continue;
      e = exp_q.pop_front();
      ok = (out_valid === e.vld) && (sum === e.sum) && (cout === e.cout);
`ifdef RCA32_FLAGS_EN
      ok = ok && (overflow === e.ovf) && (zero === e.zero);
`endif
      checks++;
      if (ok) passed++;
      else $display("FAIL %s: got vld=%b sum=%h cout=%b, want vld=%b sum=%h cout=%b ovf=%b zero=%b",
                    e.name, out_valid, sum, cout, e.vld, e.sum, e.cout, e.ovf, e.zero);
    end
  end

  initial begin
    int ta [6] = '{1, 5, 20, 4, 54, 70};
    int tb_[6] = '{2, 7, 20, 1, 10, 2};
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
    #1;

    step("reset0", 1'b0, 1'b1, 32'd5, 32'd7, 1'b0);
    step("reset1", 1'b0, 1'b1, 32'd5, 32'd7, 1'b0);
    step("first_after_reset", 1'b1, 1'b1, 32'd5, 32'd7, 1'b0);

    for (int i = 0; i < 6; i++)
      step("b2b_small", 1'b1, 1'b1, ta[i], tb_[i], 1'b1);

    step("carry_prop", 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0, 1'b1);
    step("max_ops",    1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    step("signed_ovf", 1'b1, 1'b1, 32'h7FFF_FFFF, 32'h1, 1'b0);
    step("neg_ovf",    1'b1, 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0);
    step("idle_hold",  1'b1, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);

    step("hold_load", 1'b1, 1'b1, 32'd20, 32'd20, 1'b0);
    for (int i = 0; i < 3; i++)
      step("hold_idle", 1'b1, 1'b0, $urandom, $urandom, 1'($urandom));
    step("reset_mid", 1'b0, 1'b1, 32'd20, 32'd20, 1'b0);
    step("reset_hold", 1'b1, 1'b0, 32'd3, 32'd4, 1'b0);

    for (int i = 0; i < 300; i++) begin
      logic [W-1:0] ra, rb;
      ra = $urandom; rb = $urandom;
      case ($urandom_range(0, 5))
        0: ra = 32'hFFFF_FFFF - rb;
        1: ra = 32'h7FFF_FFFF;
        default: ;
      endcase
      step("random", ($urandom_range(0, 29) != 0), ($urandom_range(0, 3) != 0),
           ra, rb, 1'($urandom));
    end

    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL drain: got %0d entries left, want 0", exp_q.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, want finish before 200000");
    $fatal(1);
  end
endmodule
